ff_apb_arbiter: RTL and testbench
=================================

Name: ff_apb_arbiter

Overview:
Shares a single APB master port between NUM_REQ on-chip requesters (e.g. debug port, DMA, boot loader) using round-robin arbitration.
- Each requester posts one read or write command at a time through a valid/ready handshake and gets a one-cycle completion pulse carrying read data.
- The block drives the APB setup and access phases with fixed timing (no pready): one SETUP cycle, then one ACCESS cycle.
- It sits between the requesters and the APB peripheral decoder, in place of a single fixed master.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
IDLE_ADDR, 20'h00bad, paddr value driven whenever no transfer is active
IDLE_DATA, 32'h00000bad, pwdata value driven whenever no write is active

Ports:
pclk  input  1  bus clock; all logic is on the rising edge
preset  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester command valid
req_write  input  NUM_REQ  per-requester: 1 = write, 0 = read
req_addr  input  NUM_REQ*20  packed addresses; requester i uses bits [20*i+19:20*i]
req_wdata  input  NUM_REQ*32  packed write data; requester i uses bits [32*i+31:32*i]
req_ready  output  NUM_REQ  one-hot accept pulse, combinational
rsp_valid  output  NUM_REQ  one-hot completion pulse, registered
rsp_rdata  output  32  read data, valid while rsp_valid is nonzero
paddr  output  20  APB address
pwrite  output  1  APB direction
psel  output  1  APB select
penable  output  1  APB enable
pwdata  output  32  APB write data
prdata  input  32  APB read data

Behaviour:
Reset values:
- psel=0, penable=0, pwrite=0.
- paddr=IDLE_ADDR, pwdata=IDLE_DATA.
- rsp_valid=0, rsp_rdata=0.
- state=IDLE, last_grant=NUM_REQ-1, so requester 0 wins the first arbitration.

FSM states: IDLE, SETUP, ACCESS.

Arbitration:
- Arbitration is allowed in IDLE, and in ACCESS (back-to-back transfers).
- The winner is the first set bit of req_valid, searching upward from last_grant+1 and wrapping modulo NUM_REQ.
- In an arbitration cycle, req_ready[g]=1 combinationally for the winner only.
- On that clock edge: latch req_write[g], req_addr[g], req_wdata[g] into the APB output registers; set last_grant=g; go to SETUP.

SETUP (1 cycle): psel=1, penable=0, paddr/pwrite/pwdata hold the latched values. Next state is ACCESS.

ACCESS (1 cycle): psel=1, penable=1.
- On the edge leaving ACCESS, rsp_valid[g] goes high for exactly one cycle.
- rsp_rdata takes prdata for reads and 32'h0 for writes.
- If any req_valid is set, arbitrate in this cycle and go straight to SETUP. psel stays 1, penable drops to 0, paddr changes to the new address.
- Otherwise go to IDLE: psel=0, penable=0, pwrite=0, paddr=IDLE_ADDR, pwdata=IDLE_DATA.

Throughput and latency:
- Back-to-back throughput is one transfer per 2 cycles.
- Latency from req_valid=1 in IDLE to rsp_valid is 3 cycles: arb at T0, SETUP T1, ACCESS T2, rsp_valid at T3.

Requester rules:
- Hold req_valid and the payload stable until req_ready.
- req_valid may be withdrawn before acceptance; the block never samples a withdrawn command.
- A requester may reassert req_valid in the cycle its rsp_valid is high. It then competes normally; round-robin places it last.

Boundary conditions:
- All requesters valid continuously: grants rotate 0,1,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ transfers.
- NUM_REQ=1: round-robin degenerates to a fixed grant; timing is unchanged.
- req_ready is never asserted in SETUP.
- At most one req_ready bit and at most one rsp_valid bit are high per cycle.
- preset during SETUP or ACCESS: all outputs return to reset values on that edge. No rsp_valid is issued for the aborted transfer, and last_grant resets.
- Unused payload lanes of non-granted requesters are don't-care.

Decomposition:
- Shared header ff_apb_defs.vh holds:
  - state encoding localparams ST_IDLE/ST_SETUP/ST_ACCESS;
  - APB_ADDR_W=20, APB_DATA_W=32;
  - APB_IDLE_ADDR/APB_IDLE_DATA, which the APB master BFM also uses.
- Sub-module ff_rr_arbiter (parameter N): inputs req[N], last[$clog2(N)], enable; outputs one-hot gnt[N] and encoded gnt_idx. It is purely combinational and reusable by other shared-resource blocks.

Test Plan:
- Single read: preset released, req_valid[0]=1, addr 20'h00010, prdata=32'hcafef00d -> req_ready[0] at T0, psel=1/penable=0 T1, penable=1 T2, rsp_valid[0]=1 with rsp_rdata=32'hcafef00d at T3, then bus idle (paddr=20'h00bad).
- Single write from requester 1: addr 20'h00020, wdata 32'h12345678 -> pwrite=1, pwdata=32'h12345678 through SETUP+ACCESS, rsp_valid[1] at T3 with rsp_rdata=0, pwdata returns to 32'h00000bad.
- Both requesters valid continuously for 6 transfers -> grant order 0,1,0,1,0,1; psel held high throughout; rsp_valid pulses every 2 cycles.
- Requester 1 asserts req_valid while requester 0's transfer is in SETUP -> requester 1 accepted in the ACCESS cycle; no idle cycle between transfers.
- preset asserted during ACCESS of a read -> next cycle psel=0, penable=0, no rsp_valid; the following request from requester 1 alone is granted normally.
- req_valid[0] pulsed for 1 cycle during another transfer's SETUP, then dropped -> never granted, never acknowledged.

Source files
------------

// File: rtl/ff_apb_arbiter_pkg.sv
// Shared APB widths, idle bus values and the arbiter state encoding.
// Also used by APB master BFMs that drive or check the idle bus pattern.
package ff_apb_arbiter_pkg;

  localparam int APB_ADDR_W = 20;
  localparam int APB_DATA_W = 32;

  localparam logic [APB_ADDR_W-1:0] APB_IDLE_ADDR = 20'h00bad;
  localparam logic [APB_DATA_W-1:0] APB_IDLE_DATA = 32'h00000bad;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Index width that stays legal when only one requester exists.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ff_apb_arbiter_if.sv
// Requester command/response lanes plus the shared APB master port.
// The slave modport is the arbiter's view; master is the requesters/peripheral side.
interface ff_apb_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import ff_apb_arbiter_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*APB_ADDR_W-1:0] req_addr;
  logic [NUM_REQ*APB_DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [APB_DATA_W-1:0]         rsp_rdata;

  logic [APB_ADDR_W-1:0]         paddr;
  logic                          pwrite;
  logic                          psel;
  logic                          penable;
  logic [APB_DATA_W-1:0]         pwdata;
  logic [APB_DATA_W-1:0]         prdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, prdata,
    output req_ready, rsp_valid, rsp_rdata,
    output paddr, pwrite, psel, penable, pwdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, prdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  paddr, pwrite, psel, penable, pwdata
  );

endinterface

// File: rtl/ff_rr_arbiter.sv
// Combinational round-robin picker: the winner is the valid request closest
// above 'last', wrapping modulo N. Zero latency; no grant while enable is low.
module ff_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          enable,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int best_d;
  int d;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    best_d  = N;
    d       = 0;
    for (int i = 0; i < N; i++) begin
      // Rotated distance: last+1 maps to 0, last itself maps to N-1.
      d = (i + N - 1 - int'(last)) % N;
      if (enable && req[i] && (d < best_d)) begin
        best_d  = d;
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/ff_apb_arbiter.sv
// Round-robin sharing of one APB master port: arbitrate, SETUP, ACCESS; response 3 cycles after accept.
// req_ready is a combinational accept pulse, offered only in IDLE and ACCESS (back-to-back every 2 cycles).
module ff_apb_arbiter
  import ff_apb_arbiter_pkg::*;
#(
  parameter int                    NUM_REQ   = 2,
  parameter logic [APB_ADDR_W-1:0] IDLE_ADDR = APB_IDLE_ADDR,
  parameter logic [APB_DATA_W-1:0] IDLE_DATA = APB_IDLE_DATA
) (
  input logic               pclk,
  input logic               preset,
  ff_apb_arbiter_if.slave   bus
);

  localparam int IW = idx_w(NUM_REQ);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

  apb_state_e            state_q, state_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         gidx_q, gidx_d;
  logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  arb_en;
  logic [NUM_REQ-1:0]    gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  sel_write;
  logic [APB_ADDR_W-1:0] sel_addr;
  logic [APB_DATA_W-1:0] sel_wdata;

  assign arb_en = (state_q == ST_IDLE) || (state_q == ST_ACCESS);

  ff_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req     (bus.req_valid),
    .last    (last_q),
    .enable  (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // One-hot payload mux keyed on the grant vector.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_write = bus.req_write[i];
        sel_addr  = bus.req_addr[i*APB_ADDR_W +: APB_ADDR_W];
        sel_wdata = bus.req_wdata[i*APB_DATA_W +: APB_DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gidx_d      = gidx_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;

    if (state_q == ST_ACCESS) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rsp_valid_d[i] = (int'(gidx_q) == i);
      end
      rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
    end

    if (state_q == ST_SETUP) begin
      state_d   = ST_ACCESS;
      psel_d    = 1'b1;
      penable_d = 1'b1;
    end else if (|gnt) begin
      state_d   = ST_SETUP;
      last_d    = gnt_idx;
      gidx_d    = gnt_idx;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      paddr_d   = sel_addr;
      pwrite_d  = sel_write;
      pwdata_d  = sel_write ? sel_wdata : IDLE_DATA;
    end else begin
      state_d   = ST_IDLE;
      psel_d    = 1'b0;
      penable_d = 1'b0;
      pwrite_d  = 1'b0;
      paddr_d   = IDLE_ADDR;
      pwdata_d  = IDLE_DATA;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      last_q      <= LAST_RST;
      gidx_q      <= '0;
      paddr_q     <= IDLE_ADDR;
      pwrite_q    <= 1'b0;
      pwdata_q    <= IDLE_DATA;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gidx_q      <= gidx_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_ff_apb_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_ff_apb_arbiter;

  localparam int N = 2;
  localparam logic [19:0] IDLE_A = 20'h00bad;
  localparam logic [31:0] IDLE_D = 32'h00000bad;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  ff_apb_arbiter_if #(.NUM_REQ(N)) bus ();

  ff_apb_arbiter #(.NUM_REQ(N)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: bus phase (0 none, 1 setup, 2 access), current transfer, pending response.
  int          m_busy = 0;
  int          m_last = N - 1;
  int          m_g = 0;
  int          m_rsp = -1;
  logic        m_write = 1'b0;
  logic [19:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;

  // Walk upward from last+1, wrapping, and take the first valid requester.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    int i;
    logic [N-1:0] t;
    i = last;
    for (int k = 0; k < N; k++) begin
      i = (i + 1 == N) ? 0 : i + 1;
      t = v >> i;
      if (t[0]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    logic [N-1:0] t;
    if (preset) begin
      m_busy = 0; m_last = N - 1; m_rsp = -1; m_rdata = '0;
      return;
    end
    m_rsp = -1; m_rdata = '0;
    if (m_busy == 2) begin
      m_rsp = m_g;
      m_rdata = m_write ? 32'h0 : bus.prdata;
    end
    if (m_busy == 1) begin
      m_busy = 2;
    end else begin
      w = rr_pick(bus.req_valid, m_last);
      if (w < 0) begin
        m_busy = 0;
      end else begin
        m_busy = 1; m_g = w; m_last = w;
        t = bus.req_write >> w;
        m_write = t[0];
        m_addr = bus.req_addr[20*w +: 20];
        m_wdata = bus.req_wdata[32*w +: 32];
      end
    end
  endtask

  task automatic advance();
    model_step();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.prdata = '0;
    @(posedge pclk); #1;
    advance();
    #1;
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite} !== 3'b000) begin
      failures++; $display("FAIL reset_ctl got=%b exp=000", {bus.psel, bus.penable, bus.pwrite});
    end
    checks++;
    if (bus.paddr !== IDLE_A || bus.pwdata !== IDLE_D) begin
      failures++; $display("FAIL reset_idle got=%h/%h exp=%h/%h", bus.paddr, bus.pwdata, IDLE_A, IDLE_D);
    end
    checks++;
    if (bus.rsp_valid !== '0 || bus.rsp_rdata !== 32'h0 || bus.req_ready !== '0) begin
      failures++; $display("FAIL reset_rsp got=%b/%h/%b exp=0", bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
    end
    preset = 1'b0;
    advance();
  endtask

  task automatic test_single_read();
    bus.req_valid = 2'b01; bus.req_write = 2'b00; bus.req_addr[19:0] = 20'h00010;
    bus.prdata = 32'hcafef00d;
    #1;
    checks++;
    if (bus.req_ready !== 2'b01 || bus.psel !== 1'b0) begin
      failures++; $display("FAIL rd_t0 ready=%b psel=%b exp=01/0", bus.req_ready, bus.psel);
    end
    advance();
    bus.req_valid = 2'b00; #1;
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite} !== 3'b100 || bus.paddr !== 20'h00010 || bus.req_ready !== 2'b00) begin
      failures++; $display("FAIL rd_setup got=%b addr=%h ready=%b exp=100/00010/00", {bus.psel, bus.penable, bus.pwrite}, bus.paddr, bus.req_ready);
    end
    advance(); #1;
    checks++;
    if ({bus.psel, bus.penable} !== 2'b11 || bus.paddr !== 20'h00010) begin
      failures++; $display("FAIL rd_access got=%b addr=%h exp=11/00010", {bus.psel, bus.penable}, bus.paddr);
    end
    advance(); #1;
    checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== 32'hcafef00d) begin
      failures++; $display("FAIL rd_rsp got=%b/%h exp=01/cafef00d", bus.rsp_valid, bus.rsp_rdata);
    end
    checks++;
    if (bus.psel !== 1'b0 || bus.paddr !== IDLE_A) begin
      failures++; $display("FAIL rd_idle psel=%b addr=%h exp=0/%h", bus.psel, bus.paddr, IDLE_A);
    end
    advance();
  endtask

  task automatic test_single_write();
    bus.req_valid = 2'b10; bus.req_write = 2'b10;
    bus.req_addr[39:20] = 20'h00020; bus.req_wdata[63:32] = 32'h12345678;
    #1;
    checks++;
    if (bus.req_ready !== 2'b10) begin
      failures++; $display("FAIL wr_ready got=%b exp=10", bus.req_ready);
    end
    advance();
    bus.req_valid = 2'b00; #1;
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite} !== 3'b101 || bus.pwdata !== 32'h12345678 || bus.paddr !== 20'h00020) begin
      failures++; $display("FAIL wr_setup got=%b %h %h exp=101 00020 12345678", {bus.psel, bus.penable, bus.pwrite}, bus.paddr, bus.pwdata);
    end
    advance(); #1;
    checks++;
    if ({bus.psel, bus.penable, bus.pwrite} !== 3'b111 || bus.pwdata !== 32'h12345678) begin
      failures++; $display("FAIL wr_access got=%b %h exp=111 12345678", {bus.psel, bus.penable, bus.pwrite}, bus.pwdata);
    end
    advance(); #1;
    checks++;
    if (bus.rsp_valid !== 2'b10 || bus.rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL wr_rsp got=%b/%h exp=10/0", bus.rsp_valid, bus.rsp_rdata);
    end
    checks++;
    if (bus.pwdata !== IDLE_D || bus.pwrite !== 1'b0 || bus.psel !== 1'b0) begin
      failures++; $display("FAIL wr_idle got=%h/%b/%b exp=%h/0/0", bus.pwdata, bus.pwrite, bus.psel, IDLE_D);
    end
    bus.req_write = 2'b00;
    advance();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] e_ready, e_rsp;
    bus.req_write = 2'b00;
    bus.req_addr[19:0] = 20'h00100; bus.req_addr[39:20] = 20'h00200;
    for (int c = 0; c < 14; c++) begin
      bus.req_valid = (c < 12) ? 2'b11 : 2'b00;
      #1;
      e_ready = (c % 2 == 0 && c < 12) ? 2'(1 << ((c / 2) % 2)) : 2'b00;
      e_rsp   = (c >= 3 && c % 2 == 1) ? 2'(1 << (((c - 3) / 2) % 2)) : 2'b00;
      checks++;
      if (bus.req_ready !== e_ready) begin
        failures++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, bus.req_ready, e_ready);
      end
      checks++;
      if (bus.rsp_valid !== e_rsp) begin
        failures++; $display("FAIL b2b_rsp c=%0d got=%b exp=%b", c, bus.rsp_valid, e_rsp);
      end
      checks++;
      if (bus.psel !== ((c >= 1 && c <= 12) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL b2b_psel c=%0d got=%b", c, bus.psel);
      end
      if (c % 2 == 1 && c < 12) begin
        checks++;
        if (bus.paddr !== ((((c - 1) / 2) % 2 == 1) ? 20'h00200 : 20'h00100)) begin
          failures++; $display("FAIL b2b_addr c=%0d got=%h", c, bus.paddr);
        end
      end
      advance();
    end
  endtask

  task automatic test_late_arrival();
    logic [1:0]  v[6]  = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [1:0]  er[6] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [1:0]  ep[6] = '{2'b00, 2'b10, 2'b11, 2'b10, 2'b11, 2'b00};
    logic [1:0]  es[6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10};
    bus.req_addr[19:0] = 20'h00030; bus.req_addr[39:20] = 20'h00040;
    for (int c = 0; c < 6; c++) begin
      bus.req_valid = v[c];
      #1;
      checks++;
      if (bus.req_ready !== er[c] || {bus.psel, bus.penable} !== ep[c] || bus.rsp_valid !== es[c]) begin
        failures++;
        $display("FAIL late c=%0d ready=%b sel_en=%b rsp=%b exp=%b/%b/%b", c, bus.req_ready, {bus.psel, bus.penable}, bus.rsp_valid, er[c], ep[c], es[c]);
      end
      if (c == 3) begin
        checks++;
        if (bus.paddr !== 20'h00040) begin
          failures++; $display("FAIL late_addr got=%h exp=00040", bus.paddr);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_abort();
    bus.req_addr[19:0] = 20'h00050; bus.req_addr[39:20] = 20'h00060;
    bus.req_valid = 2'b01; #1;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      failures++; $display("FAIL abort_ready0 got=%b exp=01", bus.req_ready);
    end
    advance();
    bus.req_valid = 2'b00; advance();
    preset = 1'b1; #1;
    checks++;
    if (bus.penable !== 1'b1) begin
      failures++; $display("FAIL abort_access got=%b exp=1", bus.penable);
    end
    advance();
    preset = 1'b0; bus.req_valid = 2'b10; #1;
    checks++;
    if ({bus.psel, bus.penable} !== 2'b00 || bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b10) begin
      failures++; $display("FAIL abort_after sel_en=%b rsp=%b ready=%b exp=00/00/10", {bus.psel, bus.penable}, bus.rsp_valid, bus.req_ready);
    end
    advance();
    bus.req_valid = 2'b00; #1;
    checks++;
    if (bus.psel !== 1'b1 || bus.paddr !== 20'h00060) begin
      failures++; $display("FAIL abort_regrant psel=%b addr=%h exp=1/00060", bus.psel, bus.paddr);
    end
    advance(); advance(); #1;
    checks++;
    if (bus.rsp_valid !== 2'b10) begin
      failures++; $display("FAIL abort_rsp got=%b exp=10", bus.rsp_valid);
    end
    advance();
  endtask

  task automatic test_withdraw();
    logic [1:0] v[7]  = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] er[7] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] es[7] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    bus.req_addr[39:20] = 20'h00070; bus.req_addr[19:0] = 20'h00080;
    for (int c = 0; c < 7; c++) begin
      bus.req_valid = v[c];
      #1;
      checks++;
      if (bus.req_ready !== er[c] || bus.rsp_valid !== es[c] || (c >= 3 && bus.psel !== 1'b0)) begin
        failures++;
        $display("FAIL withdraw c=%0d ready=%b rsp=%b psel=%b exp=%b/%b", c, bus.req_ready, bus.rsp_valid, bus.psel, er[c], es[c]);
      end
      advance();
    end
  endtask

  task automatic test_random(input int cycles);
    logic [N-1:0] pend, outs, e_ready, e_rsp;
    logic [19:0]  e_paddr;
    logic [31:0]  e_pwdata;
    int w;
    pend = '0; outs = '0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      e_rsp = (m_rsp >= 0) ? N'(1 << m_rsp) : '0;
      outs &= ~e_rsp;
      preset = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && !outs[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          bus.req_write[i] = 1'($urandom_range(0, 1));
          bus.req_addr[20*i +: 20] = 20'($urandom);
          bus.req_wdata[32*i +: 32] = $urandom;
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      bus.req_valid = pend;
      bus.prdata = $urandom;
      #1;
      w = rr_pick(pend, m_last);
      e_ready  = (m_busy != 1 && w >= 0) ? N'(1 << w) : '0;
      e_paddr  = (m_busy != 0) ? m_addr : IDLE_A;
      e_pwdata = (m_busy != 0 && m_write) ? m_wdata : IDLE_D;
      checks++;
      if (bus.req_ready !== e_ready) begin
        failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, e_ready);
      end
      checks++;
      if ({bus.psel, bus.penable, bus.pwrite} !== {m_busy != 0, m_busy == 2, m_busy != 0 && m_write}) begin
        failures++; $display("FAIL rnd_ctl cyc=%0d got=%b busy=%0d write=%b", cyc, {bus.psel, bus.penable, bus.pwrite}, m_busy, m_write);
      end
      checks++;
      if (bus.paddr !== e_paddr || bus.pwdata !== e_pwdata) begin
        failures++; $display("FAIL rnd_bus cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.paddr, bus.pwdata, e_paddr, e_pwdata);
      end
      checks++;
      if (bus.rsp_valid !== e_rsp || (m_rsp >= 0 && bus.rsp_rdata !== m_rdata)) begin
        failures++; $display("FAIL rnd_rsp cyc=%0d got=%b/%h exp=%b/%h", cyc, bus.rsp_valid, bus.rsp_rdata, e_rsp, m_rdata);
      end
      if (preset) begin
        outs = '0;
      end else begin
        pend &= ~e_ready;
        outs |= e_ready;
      end
      advance();
    end
    preset = 1'b0;
    bus.req_valid = '0;
    repeat (4) advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_late_arrival();
    test_reset_abort();
    test_withdraw();
    test_random(600);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
